// File: rtl/cache_set_pkg.sv
// Shared types and width helpers for the parametrised N-way cache set.
// The FSM state enum and the age/way index width function live here.
package cache_set_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_WAIT
    } state_t;

    localparam int DEFAULT_WAYS  = 8;
    localparam int DEFAULT_AGE_W = $clog2(DEFAULT_WAYS);

    // Ages and way indices share one width: both range over 0..ways-1.
    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// True-LRU age registers for one cache set. Age 0 is most recent,
// age WAYS-1 is the replacement candidate; ages always form a permutation.
module cache_lru_ages
    import cache_set_pkg::*;
#(
    parameter int WAYS = 8,
    localparam int AGE_W = age_width(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch,
    input  logic [AGE_W-1:0] touch_way,
    output logic [AGE_W-1:0] lru_way
);

    logic [AGE_W-1:0] age [WAYS];
    logic [AGE_W-1:0] touched_age;

    assign touched_age = age[touch_way];

    // Touched way becomes youngest; only ways younger than it age by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                age[i] <= AGE_W'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < WAYS; i++) begin
                if (AGE_W'(i) == touch_way) begin
                    age[i] <= '0;
                end else if (age[i] < touched_age) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age[i] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_set_lru.sv
// One N-way associative cache set: tag compare, true-LRU victim choice,
// fill handshake with the memory side and dirty write-back reporting.
module cache_set_lru
    import cache_set_pkg::*;
#(
    parameter int WAYS   = 8,
    parameter int TAG_W  = 24,
    parameter int HALT_W = 4,
    parameter int DATA_W = 256,
    localparam int WAY_W = age_width(WAYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_data,
    input  logic              inv_valid,
    input  logic [WAY_W-1:0]  inv_way,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [DATA_W-1:0] resp_data,
    output logic [WAYS-1:0]   halt_match,
    output logic              evict_valid,
    output logic [TAG_W-1:0]  evict_tag,
    output logic [DATA_W-1:0] evict_data,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_done
);

    state_t state;
    state_t state_next;

    logic [WAYS-1:0]         valid;
    logic [WAYS-1:0]         dirty;
    logic [HALT_W-1:0]       halt_tag [WAYS];
    logic [TAG_W-HALT_W-1:0] main_tag [WAYS];
    logic [DATA_W-1:0]       data_mem [WAYS];

    logic [TAG_W-1:0]  lat_tag;
    logic              lat_write;
    logic [DATA_W-1:0] lat_data;
    logic [WAY_W-1:0]  victim_q;

    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  halt_vec;
    logic             any_hit;
    logic             any_free;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim;

    logic             in_lookup;
    logic             accept;
    logic             do_inv;
    logic             do_fill;
    logic             hit_write;
    logic             lru_touch;
    logic [WAY_W-1:0] touch_way;

    assign in_lookup = (state == LOOKUP);
    assign accept    = (state == IDLE) && req_valid;
    assign do_inv    = (state == IDLE) && !req_valid && inv_valid;
    assign do_fill   = (state == MISS_WAIT) && fill_valid && !reset;
    assign hit_write = in_lookup && any_hit && lat_write && !reset;

    // The halt-tag field is compared on its own so halt_match can be exported.
    always_comb begin
        hit_vec  = '0;
        halt_vec = '0;
        for (int i = 0; i < WAYS; i++) begin
            halt_vec[i] = valid[i] && (halt_tag[i] == lat_tag[HALT_W-1:0]);
            hit_vec[i]  = halt_vec[i] && (main_tag[i] == lat_tag[TAG_W-1:HALT_W]);
        end
    end

    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way = WAY_W'(i);
            end
            if (!valid[i]) begin
                free_way = WAY_W'(i);
            end
        end
    end

    assign any_hit  = |hit_vec;
    assign any_free = ~&valid;
    assign victim   = any_free ? free_way : lru_way;

    assign lru_touch = (in_lookup && any_hit) || do_fill;
    assign touch_way = do_fill ? victim_q : hit_way;

    cache_lru_ages #(
        .WAYS (WAYS)
    ) ages (
        .clk       (clk),
        .reset     (reset),
        .touch     (lru_touch),
        .touch_way (touch_way),
        .lru_way   (lru_way)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Responses are decoded from the LOOKUP state, one cycle after accept.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_way    = '0;
        resp_data   = '0;
        halt_match  = '0;
        evict_valid = 1'b0;
        evict_tag   = '0;
        evict_data  = '0;
        fill_done   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_valid = 1'b1;
                halt_match = halt_vec;
                if (any_hit) begin
                    resp_hit   = 1'b1;
                    resp_way   = hit_way;
                    resp_data  = data_mem[hit_way];
                    state_next = IDLE;
                end else begin
                    resp_way    = victim;
                    evict_valid = valid[victim] && dirty[victim];
                    evict_tag   = {main_tag[victim], halt_tag[victim]};
                    evict_data  = data_mem[victim];
                    state_next  = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                fill_done = fill_valid && !reset;
                if (fill_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            dirty    <= '0;
            victim_q <= '0;
        end else begin
            if (do_inv) begin
                valid[inv_way] <= 1'b0;
                dirty[inv_way] <= 1'b0;
            end
            if (hit_write) begin
                dirty[hit_way] <= 1'b1;
            end
            if (in_lookup && !any_hit) begin
                victim_q <= victim;
            end
            if (do_fill) begin
                valid[victim_q] <= 1'b1;
                dirty[victim_q] <= lat_write;
            end
        end
    end

    // Tag and data arrays are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_tag   <= req_tag;
            lat_write <= req_write;
            lat_data  <= req_data;
        end
        if (hit_write) begin
            data_mem[hit_way] <= lat_data;
        end
        if (do_fill) begin
            halt_tag[victim_q] <= lat_tag[HALT_W-1:0];
            main_tag[victim_q] <= lat_tag[TAG_W-1:HALT_W];
            data_mem[victim_q] <= lat_write ? lat_data : fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && in_lookup) begin
            hit_unique: assert ($onehot0(hit_vec));
        end
    end

endmodule
